// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
//   Shared types and defaults for the universal shift register sequencer.
//
//   Contents:
//     USR_WIDTH / USR_CNT_W  default datapath width and shift-count width
//     sel_e                  datapath mode select encoding (also the command op)
//     state_e                sequencer FSM states
//     accept_target()        state entered when a command is accepted
// -----------------------------------------------------------------------------
package usr_pkg;

  localparam int USR_WIDTH = 4;
  localparam int USR_CNT_W = 3;

  // The command op uses the same encoding as the datapath select, so a
  // registered op can be driven straight onto sr_sel during SHIFT.
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } sel_e;

  // State names carry an ST_ prefix because LOAD is already taken by sel_e
  // and enum literals share the package scope.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Hold and zero-length shifts skip straight to DONE so the datapath is
  // never touched for them.
  function automatic state_e accept_target(input sel_e op, input logic cnt_zero);
    state_e tgt;
    case (op)
      LOAD:     tgt = ST_LOAD;
      SHR, SHL: tgt = cnt_zero ? ST_DONE : ST_SHIFT;
      default:  tgt = ST_DONE;
    endcase
    return tgt;
  endfunction

endpackage : usr_pkg

// File: rtl/usr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// usr_seq_ctrl
//   Command-driven sequencer for a universal shift register datapath. A host
//   hands over load / shift / hold commands on a valid/ready handshake; the
//   sequencer drives the datapath mode select, parallel input and serial fill
//   bits for the required number of cycles and reports completion with a
//   one-cycle done pulse.
//
//   Parameters:
//     WIDTH       datapath width (default 4)
//     CNT_W       shift-count width; max shift per command is 2^CNT_W-1
//
//   Ports:
//     CLK         clock, all state updates on the rising edge
//     Clear       synchronous active-high reset
//     cmd_valid   command present
//     cmd_ready   command can be accepted (IDLE and not in Clear)
//     cmd_op      00 hold, 01 shift right, 10 shift left, 11 parallel load
//     cmd_data    load value
//     cmd_count   number of shift cycles
//     cmd_fill    serial fill bit for shifts
//     cmd_rotate  rotate instead of fill (only with USR_ROTATE_EN)
//     busy        high whenever the FSM is not IDLE
//     done        one-cycle completion pulse
//     sr_clear_b  active-low clear to the datapath (= !Clear)
//     sr_sel      datapath mode select
//     sr_in       datapath parallel input
//     sr_msb_in   datapath right-shift serial input
//     sr_lsb_in   datapath left-shift serial input
//     sr_out      datapath current value (rotate feedback)
//
//   Build option:
//     USR_ROTATE_EN  adds cmd_rotate; a registered rotate bit feeds the bit
//                    shifted out back in at the other end. Without it the
//                    fill bit always comes from cmd_fill.
//
//   All datapath-facing outputs are decoded from registered state only, so
//   there is no combinational path from cmd_* to sr_*.
// -----------------------------------------------------------------------------
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH,
  parameter int CNT_W = USR_CNT_W
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
`ifdef USR_ROTATE_EN
  input  logic             cmd_rotate,
`endif
  output logic             busy,
  output logic             done,
  output logic             sr_clear_b,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_in,
  output logic             sr_msb_in,
  output logic             sr_lsb_in,
  input  logic [WIDTH-1:0] sr_out
);

  // ---------------------------------------------------------------------------
  // State and registered command
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  sel_e             op_q,    op_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;    // remaining shift cycles
  logic             fill_q,  fill_d;
  logic             rot_q,   rot_d;

  logic             accept;
  logic             fill_right;        // value for sr_msb_in during SHR
  logic             fill_left;         // value for sr_lsb_in during SHL

  // The controller reset and the datapath clear share the same edge.
  assign sr_clear_b = ~Clear;

  assign accept = cmd_valid & cmd_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (Clear) begin
      state_q <= ST_IDLE;
      op_q    <= HOLD;
      data_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      rot_q   <= rot_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first; a
  // path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    rot_d   = rot_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = sel_e'(cmd_op);
          data_d  = cmd_data;
          cnt_d   = cmd_count;
          fill_d  = cmd_fill;
`ifdef USR_ROTATE_EN
          rot_d   = cmd_rotate;
`else
          rot_d   = 1'b0;
`endif
          state_d = accept_target(sel_e'(cmd_op), cmd_count == '0);
        end
      end

      ST_LOAD: begin
        state_d = ST_DONE;
      end

      ST_SHIFT: begin
        // Each SHIFT cycle ends in one datapath edge; leaving on remaining=1
        // yields exactly the requested number of edges.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Serial fill selection
  // ---------------------------------------------------------------------------
`ifdef USR_ROTATE_EN
  // Rotate feeds back the bit that falls off the opposite end.
  assign fill_right = rot_q ? sr_out[0]       : fill_q;
  assign fill_left  = rot_q ? sr_out[WIDTH-1] : fill_q;
`else
  assign fill_right = fill_q;
  assign fill_left  = fill_q;
`endif

  // sr_out bits that the fill logic does not consume (all of them when
  // rotate is compiled out) are folded here so they are visibly accounted for.
  logic unused_sr_out;
  assign unused_sr_out = ^{sr_out, rot_q};

  // ---------------------------------------------------------------------------
  // Output decode (Moore: registered state only, except cmd_ready which is
  // also gated by Clear so nothing is accepted on a reset edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    sr_sel    = HOLD;
    sr_in     = '0;
    sr_msb_in = 1'b0;
    sr_lsb_in = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = ~Clear;
      end

      ST_LOAD: begin
        busy   = 1'b1;
        sr_sel = LOAD;
        sr_in  = data_q;
      end

      ST_SHIFT: begin
        busy   = 1'b1;
        sr_sel = op_q;
        // Only SHR/SHL ever reach SHIFT; the unused serial input stays 0.
        if (op_q == SHR) begin
          sr_msb_in = fill_right;
        end else if (op_q == SHL) begin
          sr_lsb_in = fill_left;
        end
      end

      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end

      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

endmodule : usr_seq_ctrl

// File: tb/tb_usr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usr_seq_ctrl
//   Self-checking bench for usr_seq_ctrl. A behavioural universal shift
//   register closes the loop on sr_out. Commands come from a table of
//   {command, expected final value, done latency, shift edges}; expectations
//   are pushed to a scoreboard queue on accept and popped on done. Hand-written
//   sequences cover reset, back-pressure while busy, abort by Clear and
//   (with USR_ROTATE_EN) rotation.
// -----------------------------------------------------------------------------
module tb_usr_seq_ctrl;
  import usr_pkg::*;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          Clear;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [CW-1:0] cmd_count;
  logic          cmd_fill;
`ifdef USR_ROTATE_EN
  logic          cmd_rotate;
`endif
  logic          busy;
  logic          done;
  logic          sr_clear_b;
  logic [1:0]    sr_sel;
  logic [W-1:0]  sr_in;
  logic          sr_msb_in;
  logic          sr_lsb_in;
  logic [W-1:0]  sr_out;

  usr_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK        (CLK),
    .Clear      (Clear),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_count  (cmd_count),
    .cmd_fill   (cmd_fill),
`ifdef USR_ROTATE_EN
    .cmd_rotate (cmd_rotate),
`endif
    .busy       (busy),
    .done       (done),
    .sr_clear_b (sr_clear_b),
    .sr_sel     (sr_sel),
    .sr_in      (sr_in),
    .sr_msb_in  (sr_msb_in),
    .sr_lsb_in  (sr_lsb_in),
    .sr_out     (sr_out)
  );

  always #5 CLK = ~CLK;

  // Posedge counter: at a negedge, cyc equals the number of rising edges so
  // far, so the current cycle index is cyc+1 and the next edge is cyc+1.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural datapath with synchronous active-low clear.
  logic [W-1:0] sr_q;
  always @(posedge CLK) begin
    if (!sr_clear_b) sr_q <= '0;
    else begin
      case (sr_sel)
        2'b01:   sr_q <= {sr_msb_in, sr_q[W-1:1]};
        2'b10:   sr_q <= {sr_q[W-2:0], sr_lsb_in};
        2'b11:   sr_q <= sr_in;
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign sr_out = sr_q;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  data;
    logic [CW-1:0] count;
    logic          fill;
    logic [W-1:0]  exp_value;  // sr_out when done is high
    int            lat;        // done cycle minus accept edge
    int            edges;      // datapath-modifying cycles
  } vec_t;

  typedef struct {
    logic [W-1:0] value;
    int           done_cyc;
    int           edges;
  } exp_t;

  exp_t sb_q[$];

  // ---------------------------------------------------------------------------
  // Per-cycle monitor of the datapath drive against the active command
  // ---------------------------------------------------------------------------
  logic         mon_en   = 1'b0;
  logic [1:0]   mon_op   = 2'b00;
  logic [W-1:0] mon_data = '0;
  logic         mon_fill = 1'b0;
  logic         mon_rot  = 1'b0;
  int           edge_cnt = 0;

  always @(negedge CLK) begin
    logic exp_msb, exp_lsb;
    if (mon_en) begin
      if (sr_sel == 2'b11) check("mon_load_data", sr_in, mon_data);
      else                 check("mon_sr_in_zero", sr_in, '0);
      if (sr_sel != 2'b00) begin
        check("mon_sel_op", sr_sel, mon_op);
        edge_cnt++;
      end
      exp_msb = (sr_sel == 2'b01) ? (mon_rot ? sr_out[0]   : mon_fill) : 1'b0;
      exp_lsb = (sr_sel == 2'b10) ? (mon_rot ? sr_out[W-1] : mon_fill) : 1'b0;
      check("mon_msb_in", sr_msb_in, exp_msb);
      check("mon_lsb_in", sr_lsb_in, exp_lsb);
    end
  end

  // ---------------------------------------------------------------------------
  // One command through the scoreboard
  // ---------------------------------------------------------------------------
  task automatic run_cmd(input vec_t v, input logic rot);
    int   t;
    int   k;
    exp_t e;
    exp_t got;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check("ready_before_cmd", cmd_ready, 1'b1);
    mon_op    = v.op;
    mon_data  = v.data;
    mon_fill  = v.fill;
    mon_rot   = rot;
    edge_cnt  = 0;
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_data  = v.data;
    cmd_count = v.count;
    cmd_fill  = v.fill;
`ifdef USR_ROTATE_EN
    cmd_rotate = rot;
`endif
    k = cyc + 1;
    e.value    = v.exp_value;
    e.done_cyc = k + v.lat;
    e.edges    = v.edges;
    sb_q.push_back(e);
    @(negedge CLK);
    // Scramble the command bus after accept: the DUT must use its copy.
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = W'($urandom);
    cmd_count = CW'($urandom);
    cmd_fill  = 1'($urandom);
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    got = sb_q.pop_front();
    check("done_seen", done, 1'b1);
    check("done_cycle", cyc + 1, got.done_cyc);
    check("busy_in_done", busy, 1'b1);
    check("sel_hold_in_done", sr_sel, 2'b00);
    check("final_value", sr_out, got.value);
    check("shift_edges", edge_cnt, got.edges);
    @(negedge CLK);
    check("done_one_cycle", done, 1'b0);
    check("ready_after_done", cmd_ready, 1'b1);
    check("busy_after_done", busy, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  vec_t tbl[10];
  vec_t v;

  initial begin
    int t;
    int k;
    int d;
    int done_cnt;

    // op, data, count, fill, expected value, latency, edges
    tbl[0] = '{2'b11, 4'b1011, 3'd0, 1'b0, 4'b1011, 2, 1};  // load
    tbl[1] = '{2'b01, 4'b0000, 3'd2, 1'b1, 4'b1110, 3, 2};  // shr 2 fill 1
    tbl[2] = '{2'b10, 4'b0000, 3'd2, 1'b0, 4'b1000, 3, 2};  // shl 2 fill 0
    tbl[3] = '{2'b01, 4'b0000, 3'd0, 1'b1, 4'b1000, 1, 0};  // shr count 0
    tbl[4] = '{2'b00, 4'b1111, 3'd5, 1'b1, 4'b1000, 1, 0};  // hold
    tbl[5] = '{2'b11, 4'b0110, 3'd3, 1'b1, 4'b0110, 2, 1};  // load
    tbl[6] = '{2'b10, 4'b0000, 3'd7, 1'b1, 4'b1111, 8, 7};  // shl max count
    tbl[7] = '{2'b01, 4'b0000, 3'd3, 1'b0, 4'b0001, 4, 3};  // shr 3 fill 0
    tbl[8] = '{2'b10, 4'b0000, 3'd1, 1'b1, 4'b0011, 2, 1};  // shl 1
    tbl[9] = '{2'b01, 4'b1111, 3'd1, 1'b0, 4'b0001, 2, 1};  // shr 1

    Clear     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    cmd_count = '0;
    cmd_fill  = 1'b0;
`ifdef USR_ROTATE_EN
    cmd_rotate = 1'b0;
`endif

    // Reset
    repeat (2) @(negedge CLK);
    check("rst_clear_b", sr_clear_b, 1'b0);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_sel", sr_sel, 2'b00);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sr_in", sr_in, '0);
    Clear = 1'b0;
    @(negedge CLK);
    check("rel_ready", cmd_ready, 1'b1);
    check("rel_busy", busy, 1'b0);
    check("rel_clear_b", sr_clear_b, 1'b1);
    check("rel_sr_out", sr_out, '0);
    mon_en = 1'b1;

    // Table
    for (int i = 0; i < 10; i++) run_cmd(tbl[i], 1'b0);

    // cmd_valid held through a busy shift; next command waits for IDLE.
    mon_op = 2'b10; mon_data = '0; mon_fill = 1'b1; mon_rot = 1'b0;
    edge_cnt  = 0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_data  = '0;
    cmd_count = 3'd3;
    cmd_fill  = 1'b1;
    k = cyc + 1;
    @(negedge CLK);
    cmd_op    = 2'b11;
    cmd_data  = 4'b1010;
    cmd_count = 3'd0;
    cmd_fill  = 1'b0;
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      check("busy_ready_low", cmd_ready, 1'b0);
      @(negedge CLK);
      t++;
    end
    check("busy_done_seen", done, 1'b1);
    check("busy_ready_low_done", cmd_ready, 1'b0);
    d = cyc + 1;
    check("busy_done_cycle", d, k + 4);
    check("busy_value", sr_out, 4'b1111);
    check("busy_edges", edge_cnt, 3);
    mon_op = 2'b11; mon_data = 4'b1010; mon_fill = 1'b0;
    @(negedge CLK);
    check("held_ready_idle", cmd_ready, 1'b1);
    check("held_not_busy", busy, 1'b0);
    edge_cnt = 0;
    k = cyc + 1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    check("held_accepted_busy", busy, 1'b1);
    check("held_load_sel", sr_sel, 2'b11);
    @(negedge CLK);
    check("held_done", done, 1'b1);
    check("held_done_cycle", cyc + 1, k + 2);
    check("held_value", sr_out, 4'b1010);
    check("held_edges", edge_cnt, 1);
    @(negedge CLK);
    check("held_back_idle", cmd_ready, 1'b1);

    // Clear in the middle of a count-3 shift right.
    mon_op = 2'b01; mon_fill = 1'b0; mon_rot = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_count = 3'd3;
    cmd_fill  = 1'b0;
    @(negedge CLK);
    cmd_valid = 1'b0;
    check("abort_busy", busy, 1'b1);
    @(negedge CLK);
    check("abort_one_shift", sr_out, 4'b0101);
    Clear = 1'b1;
    @(negedge CLK);
    check("abort_idle", busy, 1'b0);
    check("abort_no_done", done, 1'b0);
    check("abort_ready_in_clear", cmd_ready, 1'b0);
    check("abort_clear_b", sr_clear_b, 1'b0);
    check("abort_sr_out", sr_out, 4'b0000);
    check("abort_sel", sr_sel, 2'b00);
    Clear = 1'b0;
    done_cnt = 0;
    repeat (4) begin
      @(negedge CLK);
      if (done === 1'b1) done_cnt++;
    end
    check("abort_done_never", done_cnt, 0);
    check("abort_ready_after", cmd_ready, 1'b1);

`ifdef USR_ROTATE_EN
    // Rotate right 1 from 1011; fill=0 must be ignored.
    v = '{2'b11, 4'b1011, 3'd0, 1'b0, 4'b1011, 2, 1};
    run_cmd(v, 1'b0);
    v = '{2'b01, 4'b0000, 3'd1, 1'b0, 4'b1101, 2, 1};
    run_cmd(v, 1'b1);
    v = '{2'b10, 4'b0000, 3'd1, 1'b0, 4'b1011, 2, 1};
    run_cmd(v, 1'b1);
`endif

    mon_en = 1'b0;
    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_usr_seq_ctrl

// File: doc/usr_seq_ctrl.md
# usr_seq_ctrl

Command-driven sequencer for the 4-bit universal shift register datapath. It accepts load, shift and hold commands over a valid/ready handshake and drives the register's mode select, parallel input and serial fill bits for the required number of cycles. It signals completion with a one-cycle `done` pulse. It sits between a host/test controller and one universal shift register instance, replacing hand-driven mode-select sequencing.

## Interface
- `WIDTH`, default 4: shift register data width.
- `CNT_W`, default 3: width of the shift-count field; maximum shift per command is 2^CNT_W-1.

- `CLK`  in  1  clock; all state updates on rising edge.
- `Clear`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load (same encoding as datapath select).
- `cmd_data`  in  WIDTH  load value (op 11 only).
- `cmd_count`  in  CNT_W  number of shift cycles (ops 01/10 only).
- `cmd_fill`  in  1  serial fill bit for shifts.
- `cmd_rotate`  in  1  rotate instead of fill; present only with `USR_ROTATE_EN`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `sr_clear_b`  out  1  active-low clear to datapath, equal to !Clear.
- `sr_sel`  out  2  datapath mode select.
- `sr_in`  out  WIDTH  datapath parallel input.
- `sr_msb_in`  out  1  datapath right-shift serial input.
- `sr_lsb_in`  out  1  datapath left-shift serial input.
- `sr_out`  in  WIDTH  datapath current value (feedback for rotate).

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`: register op, data, count, fill, rotate.
  - Next state: op 11 → LOAD; op 01/10 with count≠0 → SHIFT; op 00 or count=0 → DONE.
- **LOAD**
  - `sr_sel`=11 and `sr_in`=registered data for exactly one cycle.
  - Next state: DONE.
- **SHIFT**
  - `sr_sel`=registered op. Remaining-count register is loaded with count and decremented each SHIFT cycle.
  - Leave for DONE in the cycle where remaining=1, so exactly `count` shift edges occur.
- **Fill rules**
  - Right shift: `sr_msb_in`=fill, `sr_lsb_in`=0.
  - Left shift: `sr_lsb_in`=fill, `sr_msb_in`=0.
  - Outside SHIFT state: both serial inputs are 0.
- **DONE**
  - `done`=1, `sr_sel`=00.
  - `sr_out` holds the final value.
  - Next state: IDLE.
- **sr_sel in other states:** IDLE and DONE always drive 00 (hold). `sr_in`=0 except in LOAD.
- **During busy:** `cmd_valid` is ignored (`cmd_ready`=0). No queuing.
- **Reset values** (Clear=1): state IDLE; `cmd_ready`=0 while Clear=1; `busy`=0; `done`=0; `sr_sel`=00; `sr_in`=0; `sr_msb_in`=0; `sr_lsb_in`=0; `sr_clear_b`=0; count register=0.
- **Clear mid-command:** return to IDLE on that edge with no `done`. The datapath is cleared by the same edge via `sr_clear_b`.

## Timing
- Accept edge k. Cycle k+1 is the first LOAD/SHIFT cycle, and the datapath updates at its end.
- Load: `done` in cycle k+2; next accept at edge k+3 at the earliest (3-cycle throughput).
- Shift by N: SHIFT cycles k+1..k+N, `done` in cycle k+N+1.
- Hold or count 0: `done` in cycle k+1 and the datapath is not modified.
- All outputs are decoded from registered state (Moore). No combinational path from `cmd_*` to `sr_*`.

## Configuration
- `USR_ROTATE_EN` defined:
  - `cmd_rotate` port exists.
  - When the registered rotate bit=1, right shift drives `sr_msb_in`=`sr_out[0]` and left shift drives `sr_lsb_in`=`sr_out[WIDTH-1]`; `cmd_fill` is ignored.
- Undefined: no `cmd_rotate` port; fill always comes from `cmd_fill`. `sr_out` is then unused by the logic.

## Structure
- Package `usr_pkg`:
  - `sel_e` enum (HOLD=2'b00, SHR=2'b01, SHL=2'b10, LOAD=2'b11).
  - `state_e` enum.
  - Default `WIDTH`/`CNT_W` localparams.
- No sub-module. Single FSM plus down-counter.

## Test plan
- **Reset:** Clear=1 for 2 cycles → `sr_clear_b`=0, `cmd_ready`=0, `sr_sel`=00, `done`=0. After release → `cmd_ready`=1, `busy`=0.
- **Load:** load 1011 → one cycle with `sr_sel`=11, `sr_in`=1011; `done` next cycle; `sr_out`=1011.
- **Shift right:** shift right count 2, fill 1 from 1011 → two cycles of `sr_sel`=01, `sr_msb_in`=1; `done`; `sr_out`=1110.
- **Shift left:** shift left count 2, fill 0 from 1110 → `sr_out`=1000; `done` exactly 3 cycles after accept.
- **Count 0 and busy:** count-0 shift → `done` next cycle, `sr_sel` stays 00, `sr_out` unchanged. `cmd_valid` held high during a busy shift → not accepted until IDLE.
- **Rotate and abort:** with `USR_ROTATE_EN`, rotate right 1 from 1011 → 1101. Then Clear during a count-3 shift → IDLE next cycle, no `done`, `sr_out`=0000.
